rx_buff_arbiter: RTL and testbench

- Sequences the read side of the 128-byte HDLC RX buffer.
- Shares the single ReadBuff/RxDataBuffOut port between two requesters: the host register interface, which reads one byte at a time, and a DMA streaming drain using valid/ready.
- Ownership is decided per frame. The block also issues Drop for explicit drops, invalid frame sizes and host-idle timeouts.

---
 rtl/hdlc_rx_pkg.sv | 20 ++
 rtl/rx_idle_timer.sv | 32 +++
 rtl/rx_buff_arbiter.sv | 135 +++++++++++++
 tb/tb_rx_buff_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlc_rx_pkg.sv
// Shared types for the HDLC RX buffer read-side arbiter.
package hdlc_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_HOST,
    RD,
    CAP,
    OUT
  } rx_arb_state_t;

  typedef enum logic {
    HOST,
    DMA
  } rx_owner_t;

  localparam int RX_MAX_FRAME = 128;

endpackage

// File: rtl/rx_idle_timer.sv
// Host-idle watchdog: counts enabled cycles since the last clear and flags
// the final cycle before the limit. TIMEOUT of 0 disables it.
module rx_idle_timer #(
  parameter int TIMEOUT = 1024,
  parameter int TMR_W   = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clr,
  input  logic En,
  output logic Expired
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count <= '0;
    end else if (Clr || !En) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  if (TIMEOUT == 0) begin : gDisabled
    assign Expired = 1'b0;
  end else begin : gEnabled
    assign Expired = En && !Clr && (count == TMR_W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/rx_buff_arbiter.sv
// Read-side sequencer for the 128-byte HDLC RX buffer: hands each frame to
// either the host register port or the DMA stream and issues drops.
module rx_buff_arbiter
  import hdlc_rx_pkg::*;
#(
  parameter int MAX_FRAME = RX_MAX_FRAME,
  parameter int TIMEOUT   = 1024,
  parameter int TMR_W     = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RxReady,
  input  logic [7:0] FrameSize,
  input  logic [7:0] RxDataBuffOut,
  output logic       ReadBuff,
  output logic       Drop,
  input  logic       DmaEn,
  input  logic       HostRdReq,
  input  logic       HostDropReq,
  output logic       HostRdAck,
  output logic       HostRdErr,
  output logic [7:0] HostRdData,
  output logic       DmaValid,
  output logic [7:0] DmaData,
  output logic       DmaLast,
  input  logic       DmaReady,
  output logic       FrameLost,
  output logic       SizeErr
);

  rx_arb_state_t state;
  rx_owner_t     owner;
  logic [7:0]    remaining;
  logic [7:0]    dataReg;
  logic          errAck;

  logic dropReq, lost, sizeBad, tmo, expired;
  logic dmaOut, hostOut, handshake, errSrc;

  rx_idle_timer #(
    .TIMEOUT(TIMEOUT),
    .TMR_W  (TMR_W)
  ) uIdleTimer (
    .Clk    (Clk),
    .Rst    (Rst),
    .Clr    (HostRdReq),
    .En     (state == WAIT_HOST),
    .Expired(expired)
  );

  // Abort sources, in priority order: host drop, then loss of RxReady mid-frame.
  assign dropReq = (state != IDLE) && HostDropReq;
  assign lost    = !dropReq && !RxReady && (remaining != 8'd0) &&
                   ((state == WAIT_HOST) || (state == RD) || (state == CAP));
  assign sizeBad = (state == ARM) &&
                   ((FrameSize == 8'd0) || ({1'b0, FrameSize} > 9'(MAX_FRAME)));
  assign tmo     = (state == WAIT_HOST) && !dropReq && !lost && !HostRdReq && expired;

  // A drop in OUT withdraws the byte in the same cycle so no handshake can land.
  assign dmaOut    = (state == OUT) && (owner == DMA) && !HostDropReq;
  assign hostOut   = (state == OUT) && (owner == HOST) && !HostDropReq;
  assign handshake = dmaOut && DmaReady;

  assign errSrc = HostRdReq && !errAck &&
                  ((state == IDLE) ||
                   ((owner == DMA) && ((state == RD) || (state == CAP) || (state == OUT))));

  assign ReadBuff   = (state == RD) && !dropReq && !lost;
  assign Drop       = dropReq || sizeBad || tmo;
  assign FrameLost  = lost;
  assign SizeErr    = sizeBad;
  assign DmaValid   = dmaOut;
  assign DmaData    = dmaOut ? dataReg : 8'h00;
  assign DmaLast    = dmaOut && (remaining == 8'd0);
  assign HostRdAck  = errAck || hostOut;
  assign HostRdErr  = errAck;
  assign HostRdData = hostOut ? dataReg : 8'h00;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      owner     <= HOST;
      remaining <= 8'd0;
      dataReg   <= 8'd0;
      errAck    <= 1'b0;
    end else begin
      errAck <= errSrc;
      if (dropReq || lost) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (RxReady) state <= ARM;
          end
          ARM: begin
            remaining <= FrameSize;
            if (sizeBad) begin
              state <= IDLE;
            end else if (DmaEn) begin
              owner <= DMA;
              state <= RD;
            end else begin
              owner <= HOST;
              state <= WAIT_HOST;
            end
          end
          WAIT_HOST: begin
            if (HostRdReq) state <= RD;
            else if (tmo)  state <= IDLE;
          end
          RD: begin
            if (remaining != 8'd0) remaining <= remaining - 8'd1;
            state <= CAP;
          end
          CAP: begin
            dataReg <= RxDataBuffOut;
            state   <= OUT;
          end
          OUT: begin
            if (owner == DMA) begin
              if (handshake) state <= (remaining != 8'd0) ? RD : IDLE;
            end else begin
              state <= (remaining != 8'd0) ? WAIT_HOST : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A read with nothing left would underflow the byte count.
  assert property (@(posedge Clk) disable iff (!Rst) (state == RD) |-> (remaining != 8'd0));

endmodule

// File: tb/tb_rx_buff_arbiter.sv
// Scoreboard bench for rx_buff_arbiter with a small RX buffer model.
module tb_rx_buff_arbiter;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       RxReady;
  logic [7:0] FrameSize;
  logic [7:0] RxDataBuffOut;
  logic       ReadBuff, Drop;
  logic       DmaEn, HostRdReq, HostDropReq;
  logic       HostRdAck, HostRdErr;
  logic [7:0] HostRdData;
  logic       DmaValid, DmaLast, DmaReady;
  logic [7:0] DmaData;
  logic       FrameLost, SizeErr;
  logic [23:0] allOuts;

  rx_buff_arbiter #(.MAX_FRAME(128), .TIMEOUT(8), .TMR_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .RxReady(RxReady), .FrameSize(FrameSize),
    .RxDataBuffOut(RxDataBuffOut), .ReadBuff(ReadBuff), .Drop(Drop),
    .DmaEn(DmaEn), .HostRdReq(HostRdReq), .HostDropReq(HostDropReq),
    .HostRdAck(HostRdAck), .HostRdErr(HostRdErr), .HostRdData(HostRdData),
    .DmaValid(DmaValid), .DmaData(DmaData), .DmaLast(DmaLast),
    .DmaReady(DmaReady), .FrameLost(FrameLost), .SizeErr(SizeErr)
  );

  always #5 Clk = ~Clk;

  assign allOuts = {ReadBuff, Drop, HostRdAck, HostRdErr, HostRdData,
                    DmaValid, DmaData, DmaLast, FrameLost, SizeErr};

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int rbCnt = 0, dropCnt = 0, sizeErrCnt = 0, lostCnt = 0, hsCnt = 0, hostAcks = 0;
  int dropCyc = 0;
  int rbCyc[$];
  logic [8:0] expDma[$];
  logic [8:0] expHost[$];

  logic [7:0] mem [0:255];
  logic [7:0] ptr;
  int         curSize;
  logic       sReadBuff, sDrop, sDmaValid;
  logic [7:0] sDmaData;

  // One clock: sample at negedge, score transfers, then advance the buffer model.
  task automatic step();
    logic [8:0] e;
    @(negedge Clk);
    cycle++;
    sReadBuff = ReadBuff; sDrop = Drop; sDmaValid = DmaValid; sDmaData = DmaData;
    if (ReadBuff) begin rbCnt++; rbCyc.push_back(cycle); end
    if (Drop) begin dropCnt++; dropCyc = cycle; end
    if (SizeErr) sizeErrCnt++;
    if (FrameLost) lostCnt++;
    if (DmaValid && DmaReady) begin
      hsCnt++;
      checks++;
      if (expDma.size() == 0) begin
        errors++;
        $display("FAIL dma_unexpected: got last=%b data=%h, required no transfer", DmaLast, DmaData);
      end else begin
        e = expDma.pop_front();
        if ({DmaLast, DmaData} !== e) begin
          errors++;
          $display("FAIL dma_byte: got last=%b data=%h, required last=%b data=%h",
                   DmaLast, DmaData, e[8], e[7:0]);
        end
      end
    end
    if (HostRdAck) begin
      hostAcks++;
      checks++;
      if (expHost.size() == 0) begin
        errors++;
        $display("FAIL host_unexpected: got err=%b data=%h, required no ack", HostRdErr, HostRdData);
      end else begin
        e = expHost.pop_front();
        if ({HostRdErr, HostRdData} !== e) begin
          errors++;
          $display("FAIL host_ack: got err=%b data=%h, required err=%b data=%h",
                   HostRdErr, HostRdData, e[8], e[7:0]);
        end
      end
    end
    @(posedge Clk);
    #1;
    if (sReadBuff) begin
      RxDataBuffOut = mem[ptr];
      ptr = ptr + 8'd1;
      if (int'(ptr) >= curSize) RxReady = 1'b0;
    end
    if (sDrop) RxReady = 1'b0;
  endtask

  task automatic loadFrame(input logic [7:0] sz, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
    ptr = 8'd0; curSize = int'(sz); FrameSize = sz; RxReady = 1'b1;
    rbCyc.delete();
  endtask

  task automatic hostRead(input logic err, input logic [7:0] data, input int lat, input string nm);
    int n, a0;
    expHost.push_back({err, data});
    a0 = hostAcks; n = 0;
    HostRdReq = 1'b1;
    while (hostAcks == a0 && n < 20) begin step(); n++; end
    HostRdReq = 1'b0;
    checks++;
    if (hostAcks == a0) begin
      errors++; expHost.delete();
      $display("FAIL %s_timeout: got no ack in %0d cycles, required ack", nm, n);
    end else if (n - 1 != lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", nm, n - 1, lat);
    end
  endtask

  task automatic waitDmaDrain(input string nm);
    int n = 0;
    while (expDma.size() != 0 && n < 100) begin step(); n++; end
    checks++;
    if (expDma.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d bytes outstanding, required 0", nm, expDma.size());
      expDma.delete();
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0; RxReady = 1'b0; FrameSize = 8'd0; RxDataBuffOut = 8'd0;
    DmaEn = 1'b0; HostRdReq = 1'b0; HostDropReq = 1'b0; DmaReady = 1'b0;
    ptr = 8'd0; curSize = 0;
    #22;
    checks++;
    if (allOuts !== 24'd0) begin
      errors++; $display("FAIL reset_outputs: got %h, required 000000", allOuts);
    end
    @(negedge Clk); Rst = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_dma_frame();
    int r0 = rbCnt, h0 = hsCnt, d0 = dropCnt;
    DmaEn = 1'b1; DmaReady = 1'b1;
    expDma.push_back({1'b0, 8'hA1}); expDma.push_back({1'b0, 8'hB2}); expDma.push_back({1'b1, 8'hC3});
    loadFrame(8'd3, 8'hA1, 8'hB2, 8'hC3, 8'h00);
    waitDmaDrain("dma_frame");
    repeat (3) step();
    checks++;
    if (rbCnt - r0 != 3) begin errors++; $display("FAIL dma_readbuff: got %0d, required 3", rbCnt - r0); end
    checks++;
    if (hsCnt - h0 != 3) begin errors++; $display("FAIL dma_handshakes: got %0d, required 3", hsCnt - h0); end
    checks++;
    if (rbCyc.size() < 3 || rbCyc[1] - rbCyc[0] != 3 || rbCyc[2] - rbCyc[1] != 3) begin
      errors++; $display("FAIL dma_spacing: got %0d pulses with uneven spacing, required 3 cycles apart", rbCyc.size());
    end
    checks++;
    if (dropCnt != d0 || sDmaValid !== 1'b0) begin
      errors++; $display("FAIL dma_idle: got drops=%0d valid=%b, required 0 and 0", dropCnt - d0, sDmaValid);
    end
  endtask

  task automatic test_backpressure();
    int r0 = rbCnt, h0 = hsCnt, n = 0, rbAt;
    logic [7:0] held;
    DmaEn = 1'b1; DmaReady = 1'b1;
    expDma.push_back({1'b0, 8'h11}); expDma.push_back({1'b0, 8'h22}); expDma.push_back({1'b1, 8'h33});
    loadFrame(8'd3, 8'h11, 8'h22, 8'h33, 8'h00);
    while (hsCnt - h0 < 1 && n < 20) begin step(); n++; end
    DmaReady = 1'b0;
    n = 0;
    step();
    while (!sDmaValid && n < 10) begin step(); n++; end
    held = sDmaData; rbAt = rbCnt;
    checks++;
    if (held !== 8'h22) begin errors++; $display("FAIL bp_byte: got %h, required 22", held); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (sDmaValid !== 1'b1 || sDmaData !== held) begin
        errors++; $display("FAIL bp_hold: got valid=%b data=%h, required valid=1 data=%h", sDmaValid, sDmaData, held);
      end
    end
    checks++;
    if (rbCnt != rbAt) begin errors++; $display("FAIL bp_readbuff: got %0d extra, required 0", rbCnt - rbAt); end
    DmaReady = 1'b1;
    waitDmaDrain("bp");
    checks++;
    if (rbCnt - r0 != 3 || hsCnt - h0 != 3) begin
      errors++; $display("FAIL bp_totals: got rb=%0d hs=%0d, required 3 and 3", rbCnt - r0, hsCnt - h0);
    end
    DmaReady = 1'b0;
  endtask

  task automatic test_host_frame();
    DmaEn = 1'b0; DmaReady = 1'b0;
    loadFrame(8'd2, 8'h55, 8'hAA, 8'h00, 8'h00);
    step(); step();
    hostRead(1'b0, 8'h55, 3, "host_rd1");
    hostRead(1'b0, 8'hAA, 3, "host_rd2");
    step();
    hostRead(1'b1, 8'h00, 1, "host_idle");
  endtask

  task automatic test_arbitration();
    int r0 = rbCnt, h0 = hsCnt;
    DmaEn = 1'b1; DmaReady = 1'b1;
    expDma.push_back({1'b0, 8'hD1}); expDma.push_back({1'b0, 8'hD2}); expDma.push_back({1'b1, 8'hD3});
    loadFrame(8'd3, 8'hD1, 8'hD2, 8'hD3, 8'h00);
    repeat (3) step();
    hostRead(1'b1, 8'h00, 1, "arb_host");
    waitDmaDrain("arb");
    checks++;
    if (rbCnt - r0 != 3 || hsCnt - h0 != 3 || rbCyc.size() != 3 || rbCyc[2] - rbCyc[0] != 6) begin
      errors++; $display("FAIL arb_stream: got rb=%0d hs=%0d, required 3 and 3 evenly spaced", rbCnt - r0, hsCnt - h0);
    end
    step();
  endtask

  task automatic test_size();
    logic [7:0] sizes [2];
    int r0, d0, s0, c0;
    sizes[0] = 8'd0; sizes[1] = 8'hFF;
    DmaEn = 1'b1; DmaReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      r0 = rbCnt; d0 = dropCnt; s0 = sizeErrCnt; c0 = cycle;
      loadFrame(sizes[k], 8'h00, 8'h00, 8'h00, 8'h00);
      repeat (4) step();
      checks++;
      if (dropCnt - d0 != 1 || sizeErrCnt - s0 != 1 || dropCyc != c0 + 2) begin
        errors++; $display("FAIL size_%h: got drops=%0d sizeErr=%0d at %0d, required 1 and 1 at %0d",
                           sizes[k], dropCnt - d0, sizeErrCnt - s0, dropCyc, c0 + 2);
      end
      checks++;
      if (rbCnt != r0) begin errors++; $display("FAIL size_%h_readbuff: got %0d, required 0", sizes[k], rbCnt - r0); end
    end
    s0 = sizeErrCnt; d0 = dropCnt; r0 = rbCnt;
    loadFrame(8'd128, 8'h00, 8'h00, 8'h00, 8'h00);
    step(); step();
    HostDropReq = 1'b1; step(); HostDropReq = 1'b0;
    repeat (3) step();
    checks++;
    if (sizeErrCnt != s0 || dropCnt - d0 != 1 || rbCnt != r0) begin
      errors++; $display("FAIL size_max: got sizeErr=%0d drops=%0d rb=%0d, required 0 1 0",
                         sizeErrCnt - s0, dropCnt - d0, rbCnt - r0);
    end
  endtask

  task automatic test_timeout();
    int n = 0, d0, r0 = rbCnt;
    DmaEn = 1'b0;
    loadFrame(8'd2, 8'h01, 8'h02, 8'h00, 8'h00);
    step(); step();
    d0 = dropCnt;
    while (dropCnt == d0 && n < 30) begin step(); n++; end
    checks++;
    if (n != 8) begin errors++; $display("FAIL timeout_cycles: got %0d, required 8", n); end
    repeat (4) step();
    checks++;
    if (dropCnt - d0 != 1 || rbCnt != r0) begin
      errors++; $display("FAIL timeout_after: got drops=%0d rb=%0d, required 1 and 0", dropCnt - d0, rbCnt - r0);
    end
  endtask

  task automatic test_frame_lost();
    int n = 0, h0 = hsCnt, r0 = rbCnt, d0 = dropCnt, l0 = lostCnt;
    DmaEn = 1'b1; DmaReady = 1'b1;
    expDma.push_back({1'b0, 8'h41});
    loadFrame(8'd4, 8'h41, 8'h42, 8'h43, 8'h44);
    while (hsCnt == h0 && n < 20) begin step(); n++; end
    RxReady = 1'b0;
    repeat (5) step();
    checks++;
    if (lostCnt - l0 != 1 || dropCnt != d0) begin
      errors++; $display("FAIL lost_flags: got lost=%0d drops=%0d, required 1 and 0", lostCnt - l0, dropCnt - d0);
    end
    checks++;
    if (rbCnt - r0 != 1 || hsCnt - h0 != 1 || sDmaValid !== 1'b0) begin
      errors++; $display("FAIL lost_cancel: got rb=%0d hs=%0d valid=%b, required 1 1 0", rbCnt - r0, hsCnt - h0, sDmaValid);
    end
  endtask

  task automatic test_drop_out();
    int n = 0, h0 = hsCnt, r0 = rbCnt, d0 = dropCnt;
    DmaEn = 1'b1; DmaReady = 1'b0;
    loadFrame(8'd3, 8'h71, 8'h72, 8'h73, 8'h00);
    step();
    while (!sDmaValid && n < 10) begin step(); n++; end
    HostDropReq = 1'b1; DmaReady = 1'b1;
    step();
    HostDropReq = 1'b0;
    checks++;
    if (sDrop !== 1'b1 || sDmaValid !== 1'b0) begin
      errors++; $display("FAIL dropout_cycle: got drop=%b valid=%b, required 1 and 0", sDrop, sDmaValid);
    end
    repeat (4) step();
    checks++;
    if (hsCnt != h0 || rbCnt - r0 != 1 || dropCnt - d0 != 1) begin
      errors++; $display("FAIL dropout_after: got hs=%0d rb=%0d drops=%0d, required 0 1 1",
                         hsCnt - h0, rbCnt - r0, dropCnt - d0);
    end
    DmaReady = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0, r0, d0;
    DmaEn = 1'b1; DmaReady = 1'b0;
    loadFrame(8'd3, 8'h91, 8'h92, 8'h93, 8'h00);
    step();
    while (!sDmaValid && n < 10) begin step(); n++; end
    Rst = 1'b0;
    #1;
    checks++;
    if (allOuts !== 24'd0) begin
      errors++; $display("FAIL reset_mid: got %h, required 000000", allOuts);
    end
    RxReady = 1'b0; ptr = 8'd0;
    @(negedge Clk); Rst = 1'b1;
    @(posedge Clk); #1;
    r0 = rbCnt; d0 = dropCnt;
    repeat (4) step();
    checks++;
    if (rbCnt != r0 || dropCnt != d0 || sDmaValid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after: got rb=%0d drops=%0d valid=%b, required 0 0 0",
                         rbCnt - r0, dropCnt - d0, sDmaValid);
    end
  endtask

  initial begin
    test_reset();
    test_dma_frame();
    test_backpressure();
    test_host_frame();
    test_arbitration();
    test_size();
    test_timeout();
    test_frame_lost();
    test_drop_out();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 ns, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
